// File: rtl/cursor_move_ctrl_if.sv
// rtl/cursor_move_ctrl_if.sv - key/enable inputs and move-pulse outputs of the cursor move controller
interface cursor_move_ctrl_if;
  logic       enable;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       held;
  logic [1:0] dir;

  modport master (
    output enable, key_up, key_down, key_left, key_right,
    input  up, down, left, right, held, dir
  );

  modport slave (
    input  enable, key_up, key_down, key_left, key_right,
    output up, down, left, right, held, dir
  );
endinterface

// File: rtl/cursor_move_ctrl.sv
// rtl/cursor_move_ctrl.sv - synchronised direction keys to single-cycle move pulses with auto-repeat
module cursor_move_ctrl #(
  parameter int DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input logic              CLOCK_50,
  input logic              reset,
  cursor_move_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Key vectors are indexed by direction code: 0=up 1=down 2=right 3=left.
  logic [3:0]    keys;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    dir_q;
  logic          held_q;
  logic [3:0]    pulse;
  logic [1:0]    pick;
  logic          keep;

  assign keys = {bus.key_left, bus.key_right, bus.key_down, bus.key_up};

  always_comb begin
    pick = 2'd0;
    if (sync2[0])      pick = 2'd0;
    else if (sync2[1]) pick = 2'd1;
    else if (sync2[2]) pick = 2'd2;
    else if (sync2[3]) pick = 2'd3;
  end

  assign keep = bus.enable && sync2[dir_q];

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1  <= 4'b0;
      sync2  <= 4'b0;
      state  <= ST_IDLE;
      cnt    <= '0;
      dir_q  <= 2'd0;
      held_q <= 1'b0;
      pulse  <= 4'b0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      pulse <= 4'b0;
      case (state)
        ST_IDLE: begin
          if (bus.enable && (|sync2)) begin
            state  <= ST_DELAY;
            cnt    <= '0;
            dir_q  <= pick;
            held_q <= 1'b1;
            pulse  <= 4'b0001 << pick;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // Release or lockout wins even on the cycle the counter expires.
          if (!keep) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dir_q  <= 2'd0;
            held_q <= 1'b0;
          end else if ((state == ST_DELAY && cnt == CW'(DELAY_CYCLES - 1)) ||
                       (state == ST_REPEAT && cnt == CW'(REPEAT_CYCLES - 1))) begin
            state <= ST_REPEAT;
            cnt   <= '0;
            pulse <= 4'b0001 << dir_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          dir_q  <= 2'd0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.up    = pulse[0];
  assign bus.down  = pulse[1];
  assign bus.right = pulse[2];
  assign bus.left  = pulse[3];
  assign bus.held  = held_q;
  assign bus.dir   = dir_q;

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// tb/tb_cursor_move_ctrl.sv - directed and randomized checks of cursor_move_ctrl against a hold-age model
module tb_cursor_move_ctrl;

  localparam int D = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cursor_move_ctrl_if bus ();

  cursor_move_ctrl #(.DELAY_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: keys delayed two edges, then a latched direction and its age in cycles since the press.
  logic [3:0] m_s1 = 4'b0;
  logic [3:0] m_s2 = 4'b0;
  int         m_dir = -1;
  int         m_age = 0;
  logic [3:0] m_pulse = 4'b0;

  task automatic set_keys(input logic [3:0] k);
    bus.key_up    = k[0];
    bus.key_down  = k[1];
    bus.key_right = k[2];
    bus.key_left  = k[3];
  endtask

  task automatic model_edge();
    logic [3:0] k;
    k = {bus.key_left, bus.key_right, bus.key_down, bus.key_up};
    m_pulse = 4'b0;
    if (!reset) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_dir = -1; m_age = 0;
      return;
    end
    if (m_dir < 0) begin
      if (bus.enable && (m_s2 != 4'b0)) begin
        for (int i = 3; i >= 0; i--) if (m_s2[i]) m_dir = i;
        m_age = 0;
        m_pulse[m_dir] = 1'b1;
      end
    end else if (!bus.enable || !m_s2[m_dir]) begin
      m_dir = -1;
    end else begin
      m_age++;
      if (m_age == D || (m_age > D && (m_age - D) % R == 0)) m_pulse[m_dir] = 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] obs;
    @(posedge clk);
    model_edge();
    #1;
    obs = {bus.left, bus.right, bus.down, bus.up};
    check("pulses", obs, m_pulse);
    check("held", {3'b0, bus.held}, {3'b0, m_dir >= 0});
    check("dir", {2'b0, bus.dir}, (m_dir < 0) ? 4'd0 : 4'(m_dir));
    check("onehot", {3'b0, $countones(obs) <= 1}, 4'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0;
    bus.enable = 1'b1;
    set_keys(4'b0000);
    run(2);
    check("reset_idle", {bus.held, bus.up, bus.down, bus.left}, 4'b0);
    reset = 1'b1;
    run(2);

    // Hold up; release; tap right
    set_keys(4'b0001); run(20);
    set_keys(4'b0000); run(6);
    set_keys(4'b0100); run(3);
    set_keys(4'b0000); run(6);

    // Up+down+left together, then up released with down still held
    set_keys(4'b1011); run(10);
    set_keys(4'b1010); run(10);
    set_keys(4'b0000); run(6);

    // Left held with enable dropped mid-repeat
    set_keys(4'b1000); run(12);
    bus.enable = 1'b0; run(2);
    bus.enable = 1'b1; run(10);
    set_keys(4'b0000); run(5);

    // Reset during delay with key held
    set_keys(4'b0001); run(5);
    reset = 1'b0; run(1);
    check("reset_mid", {bus.held, bus.up, bus.down, bus.right}, 4'b0);
    reset = 1'b1; run(10);
    set_keys(4'b0000); run(5);

    // Down released on the expiring cycle, then one cycle longer
    set_keys(4'b0010); run(4);
    set_keys(4'b0000); run(6);
    set_keys(4'b0010); run(5);
    set_keys(4'b0000); run(6);

    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 2) == 0) set_keys(4'($urandom_range(0, 15)));
      else                           set_keys(4'b0001 << $urandom_range(0, 3));
      bus.enable = ($urandom_range(0, 9) != 0);
      reset      = ($urandom_range(0, 29) != 0);
      run($urandom_range(1, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
